// File: rtl/am2950_fifo_xcvr.sv
// am2950_fifo_xcvr: registered bidirectional FIFO bus transceiver (A->B and B->A queues)
// with Am2950-style full/empty flags. Define AM2950_OVF_EN to add sticky ovf_ab/ovf_ba flags.
module am2950_fifo_xcvr #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int INVERT = 1
) (
  input  logic                   clk,
  input  logic                   reset_,
`ifdef AM2950_OVF_EN
  output logic                   ovf_ab,
  output logic                   ovf_ba,
`endif
  inout  wire  [WIDTH-1:0]       a,
  inout  wire  [WIDTH-1:0]       b,
  input  logic                   ld_ab,
  input  logic                   rd_ab,
  input  logic                   oe_b,
  input  logic                   ld_ba,
  input  logic                   rd_ba,
  input  logic                   oe_a,
  output logic                   empty_ab,
  output logic                   full_ab,
  output logic                   empty_ba,
  output logic                   full_ba,
  output logic [$clog2(DEPTH):0] cnt_ab,
  output logic [$clog2(DEPTH):0] cnt_ba
);

  localparam int AW = $clog2(DEPTH);

  // Index 0 is the A->B direction, index 1 is B->A.
  logic [1:0][WIDTH-1:0] din;
  logic [1:0]            ld;
  logic [1:0]            rd;
  logic [1:0]            oe;

  assign din = {b, a};
  // A direction cannot capture the bus it is itself driving.
  assign ld  = {ld_ba & ~oe_b, ld_ab & ~oe_a};
  assign rd  = {rd_ba, rd_ab};
  assign oe  = {oe_a, oe_b};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dir
      logic [WIDTH-1:0] mem [DEPTH];
      logic [WIDTH-1:0] head_reg;
      logic [WIDTH-1:0] drive_val;
      logic [AW-1:0]    wr_ptr_reg;
      logic [AW-1:0]    rd_ptr_reg;
      logic [AW-1:0]    rd_ptr_next;
      logic [AW:0]      cnt_reg;
      logic [AW:0]      cnt_next;
      logic             empty_reg;
      logic             full_reg;
      logic             do_push;
      logic             do_pop;

      always_comb begin
        do_pop      = rd[gi] & ~empty_reg;
        do_push     = ld[gi] & (~full_reg | do_pop);
        rd_ptr_next = rd_ptr_reg + AW'(do_pop);
        cnt_next    = cnt_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end

      always_ff @(posedge clk) begin
        if (!reset_) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          cnt_reg    <= '0;
          empty_reg  <= 1'b1;
          full_reg   <= 1'b0;
        end else begin
          if (do_push)
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
          rd_ptr_reg <= rd_ptr_next;
          cnt_reg    <= cnt_next;
          empty_reg  <= (cnt_next == '0);
          full_reg   <= (cnt_next == (AW+1)'(DEPTH));
        end
      end

      // Head is a registered read of the next head slot, bypassing the incoming
      // word when that slot is the one being written on this edge.
      always_ff @(posedge clk) begin
        if (do_push && reset_)
          mem[wr_ptr_reg] <= din[gi];
        if (do_push && (rd_ptr_next == wr_ptr_reg))
          head_reg <= din[gi];
        else
          head_reg <= mem[rd_ptr_next];
      end

      assign drive_val = (INVERT != 0) ? ~head_reg : head_reg;

      if (gi == 0) begin : g_drive_b
        assign b = (oe[gi] && !empty_reg) ? drive_val : {WIDTH{1'bz}};
      end else begin : g_drive_a
        assign a = (oe[gi] && !empty_reg) ? drive_val : {WIDTH{1'bz}};
      end

`ifdef AM2950_OVF_EN
      logic ovf_reg;
      always_ff @(posedge clk) begin
        if (!reset_)
          ovf_reg <= 1'b0;
        else if ((ld[gi] & full_reg & ~rd[gi]) | (rd[gi] & empty_reg))
          ovf_reg <= 1'b1;
      end
`endif
    end
  endgenerate

  assign empty_ab = g_dir[0].empty_reg;
  assign full_ab  = g_dir[0].full_reg;
  assign cnt_ab   = g_dir[0].cnt_reg;
  assign empty_ba = g_dir[1].empty_reg;
  assign full_ba  = g_dir[1].full_reg;
  assign cnt_ba   = g_dir[1].cnt_reg;
`ifdef AM2950_OVF_EN
  assign ovf_ab   = g_dir[0].ovf_reg;
  assign ovf_ba   = g_dir[1].ovf_reg;
`endif

endmodule

// File: tb/tb_am2950_fifo_xcvr.sv
// tb_am2950_fifo_xcvr: directed self-checking bench for am2950_fifo_xcvr
// (WIDTH=8, DEPTH=4; u_dut inverting, u_dut_t true polarity).
module tb_am2950_fifo_xcvr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_ = 1'b1;
  logic       ld_ab = 1'b0, rd_ab = 1'b0, oe_b = 1'b0;
  logic       ld_ba = 1'b0, rd_ba = 1'b0, oe_a = 1'b0;
  logic [7:0] a_drv = 8'h00, b_drv = 8'h00;
  logic       a_en = 1'b0, b_en = 1'b0;
  wire  [7:0] a, b;
  wire        empty_ab, full_ab, empty_ba, full_ba;
  wire  [2:0] cnt_ab, cnt_ba;

  assign a = a_en ? a_drv : 8'hzz;
  assign b = b_en ? b_drv : 8'hzz;

  logic       ld_ba_t = 1'b0, oe_a_t = 1'b0;
  logic [7:0] b_t_drv = 8'h00;
  logic       b_t_en = 1'b0;
  wire  [7:0] a_t, b_t;
  wire        empty_ab_t, full_ab_t, empty_ba_t, full_ba_t;
  wire  [2:0] cnt_ab_t, cnt_ba_t;

  assign b_t = b_t_en ? b_t_drv : 8'hzz;

`ifdef AM2950_OVF_EN
  wire ovf_ab, ovf_ba, ovf_ab_t, ovf_ba_t;
`endif

  am2950_fifo_xcvr #(.WIDTH(8), .DEPTH(4), .INVERT(1)) u_dut (
    .clk(clk), .reset_(reset_),
`ifdef AM2950_OVF_EN
    .ovf_ab(ovf_ab), .ovf_ba(ovf_ba),
`endif
    .a(a), .b(b),
    .ld_ab(ld_ab), .rd_ab(rd_ab), .oe_b(oe_b),
    .ld_ba(ld_ba), .rd_ba(rd_ba), .oe_a(oe_a),
    .empty_ab(empty_ab), .full_ab(full_ab), .empty_ba(empty_ba), .full_ba(full_ba),
    .cnt_ab(cnt_ab), .cnt_ba(cnt_ba)
  );

  am2950_fifo_xcvr #(.WIDTH(8), .DEPTH(4), .INVERT(0)) u_dut_t (
    .clk(clk), .reset_(reset_),
`ifdef AM2950_OVF_EN
    .ovf_ab(ovf_ab_t), .ovf_ba(ovf_ba_t),
`endif
    .a(a_t), .b(b_t),
    .ld_ab(1'b0), .rd_ab(1'b0), .oe_b(1'b0),
    .ld_ba(ld_ba_t), .rd_ba(1'b0), .oe_a(oe_a_t),
    .empty_ab(empty_ab_t), .full_ab(full_ab_t), .empty_ba(empty_ba_t), .full_ba(full_ba_t),
    .cnt_ab(cnt_ab_t), .cnt_ba(cnt_ba_t)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ab(input logic [7:0] v);
    a_drv = v; a_en = 1'b1; ld_ab = 1'b1;
    tick();
    ld_ab = 1'b0; a_en = 1'b0;
  endtask

  task automatic pop_ab();
    rd_ab = 1'b1;
    tick();
    rd_ab = 1'b0;
  endtask

  // A released bus reads back exactly what the bench drives onto it.
  task automatic probe_a(input string tag);
    a_drv = 8'h00; a_en = 1'b1; #1;
    check(tag, a, 8'h00);
    a_en = 1'b0; #1;
  endtask

  task automatic probe_b(input string tag);
    b_drv = 8'h00; b_en = 1'b1; #1;
    check(tag, b, 8'h00);
    b_en = 1'b0; #1;
  endtask

  logic [7:0] t3_exp [4] = '{8'hFE, 8'hFD, 8'hFC, 8'hFB};
  logic [7:0] t4_exp [4] = '{8'hDD, 8'hCC, 8'hBB, 8'h55};
  logic [7:0] e;

  initial begin
    // 1: reset wins over a same-cycle push
    reset_ = 1'b0; oe_b = 1'b1; a_drv = 8'h33; a_en = 1'b1; ld_ab = 1'b1;
    tick();
    reset_ = 1'b1; ld_ab = 1'b0; a_en = 1'b0;
    check("rst cnt_ab", cnt_ab, 0);
    check("rst empty_ab", empty_ab, 1);
    check("rst full_ab", full_ab, 0);
    check("rst cnt_ba", cnt_ba, 0);
    check("rst empty_ba", empty_ba, 1);
    check("rst full_ba", full_ba, 0);
    check("rst t empty_ab", empty_ab_t, 1);
    check("rst t full_ab", full_ab_t, 0);
    check("rst t cnt_ab", cnt_ab_t, 0);
    check("rst t empty_ba", empty_ba_t, 1);
    check("rst t full_ba", full_ba_t, 0);
    check("rst t cnt_ba", cnt_ba_t, 0);
    probe_b("rst b z");
    probe_a("rst a z");
`ifdef AM2950_OVF_EN
    check("rst ovf_ab", ovf_ab, 0);
    check("rst ovf_ba", ovf_ba, 0);
    check("rst t ovf_ab", ovf_ab_t, 0);
    check("rst t ovf_ba", ovf_ba_t, 0);
`endif

    // 2: single word, inverted on b the cycle after the push
    push_ab(8'h33);
    check("t2 b", b, 8'hCC);
    check("t2 cnt_ab", cnt_ab, 1);
    check("t2 empty_ab", empty_ab, 0);
    pop_ab();
    check("t2 pop empty_ab", empty_ab, 1);
    check("t2 pop cnt_ab", cnt_ab, 0);
    probe_b("t2 b z");

    // 3: fill, overfill, drain, underflow
    for (int i = 1; i <= 4; i++) push_ab(8'(i));
    check("t3 full_ab", full_ab, 1);
    check("t3 cnt_ab", cnt_ab, 4);
    push_ab(8'h05);
    check("t3 ovr cnt_ab", cnt_ab, 4);
    check("t3 ovr full_ab", full_ab, 1);
`ifdef AM2950_OVF_EN
    check("t3 ovf_ab", ovf_ab, 1);
    check("t3 ovf_ba", ovf_ba, 0);
`endif
    for (int i = 0; i < 4; i++) begin
      check("t3 head", b, t3_exp[i]);
      pop_ab();
    end
    check("t3 drained empty", empty_ab, 1);
    pop_ab();
    check("t3 udf cnt_ab", cnt_ab, 0);
    check("t3 udf empty_ab", empty_ab, 1);

    // 4: push+pop while full, then while empty
    push_ab(8'h11); push_ab(8'h22); push_ab(8'h33); push_ab(8'h44);
    a_drv = 8'hAA; a_en = 1'b1; ld_ab = 1'b1; rd_ab = 1'b1;
    tick();
    ld_ab = 1'b0; rd_ab = 1'b0; a_en = 1'b0;
    check("t4 full cnt_ab", cnt_ab, 4);
    check("t4 full_ab", full_ab, 1);
    for (int i = 0; i < 4; i++) begin
      check("t4 head", b, t4_exp[i]);
      pop_ab();
    end
    check("t4 drained empty", empty_ab, 1);
    a_drv = 8'h5A; a_en = 1'b1; ld_ab = 1'b1; rd_ab = 1'b1;
    tick();
    ld_ab = 1'b0; rd_ab = 1'b0; a_en = 1'b0;
    check("t4 empty ldrd cnt", cnt_ab, 1);
    check("t4 empty ldrd b", b, 8'hA5);
    pop_ab();
    check("t4 final empty", empty_ab, 1);

    // 5: B->A direction and loopback guard
    oe_b = 1'b0;
    b_drv = 8'h0F; b_en = 1'b1; ld_ba = 1'b1;
    tick();
    ld_ba = 1'b0; b_en = 1'b0;
    check("t5 cnt_ba", cnt_ba, 1);
    oe_a = 1'b1; ld_ab = 1'b1; #1;
    check("t5 a", a, 8'hF0);
    tick();
    ld_ab = 1'b0;
    check("t5 guard cnt_ab", cnt_ab, 0);
    check("t5 guard empty_ab", empty_ab, 1);
    check("t5 a hold", a, 8'hF0);
    rd_ba = 1'b1;
    tick();
    rd_ba = 1'b0; oe_a = 1'b0;
    check("t5 empty_ba", empty_ba, 1);
    b_t_drv = 8'h0F; b_t_en = 1'b1; ld_ba_t = 1'b1;
    tick();
    ld_ba_t = 1'b0; b_t_en = 1'b0; oe_a_t = 1'b1; #1;
    check("t5 true a", a_t, 8'h0F);
    check("t5 true cnt_ba", cnt_ba_t, 1);

    // 6: pointer wrap with steady occupancy, then reset mid-stream
    oe_b = 1'b1;
    push_ab(8'h10); push_ab(8'h11);
    for (int i = 0; i < 8; i++) begin
      e = 8'hEF - 8'(i);
      check("t6 head", b, e);
      a_drv = 8'h12 + 8'(i); a_en = 1'b1; ld_ab = 1'b1; rd_ab = 1'b1;
      tick();
      ld_ab = 1'b0; rd_ab = 1'b0; a_en = 1'b0;
      check("t6 cnt_ab", cnt_ab, 2);
    end
    check("t6 wrap head", b, 8'hE7);
    reset_ = 1'b0; a_drv = 8'h99; a_en = 1'b1; ld_ab = 1'b1;
    tick();
    reset_ = 1'b1; ld_ab = 1'b0; a_en = 1'b0;
    check("t6 rst cnt_ab", cnt_ab, 0);
    check("t6 rst empty_ab", empty_ab, 1);
    check("t6 rst full_ab", full_ab, 0);
    check("t6 rst t cnt_ba", cnt_ba_t, 0);
    probe_b("t6 rst b z");
    probe_a("t6 rst a z");
`ifdef AM2950_OVF_EN
    check("t6 rst ovf_ab", ovf_ab, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
